// File: rtl/prio_pkg.sv
// Shared constants, FSM encoding and the index-to-one-hot helper
// for the priority acknowledge return path.
package prio_pkg;

    localparam int IDX_W = 3;
    localparam int N     = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_ack_decoder_idx_fifo.sv
// Circular pending-index FIFO; exposes every slot plus a per-slot valid
// flag so the owner can search for duplicates.
module idx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic [CW-1:0]             count,
    output logic [DEPTH-1:0][W-1:0]   entries,
    output logic [DEPTH-1:0]          valid
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout    = mem[rd_ptr];
    assign entries = mem;

    // A slot is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        assign valid[g] = {1'b0, PW'(g) - rd_ptr} < count;
    end

endmodule

// File: rtl/prio_ack_decoder.sv
// Queues encoded request indices and replays them, in order, as held
// one-hot acknowledges with a completion pulse and duplicate filtering.
module prio_ack_decoder
    import prio_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int HOLD_MIN = 2,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_in,
    input  logic             idx_valid,
    output logic             idx_ready,
    input  logic [N-1:0]     src_clr,
    output logic [N-1:0]     ack_out,
    output logic             ack_valid,
    output logic             done,
    output logic [IDX_W-1:0] done_idx,
    output logic             dup_drop,
    output logic [CW-1:0]    fifo_count,
    output state_t           fsm_state
);

    localparam int HC_W                 = $clog2(HOLD_MIN + 2);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MIN);

    state_t                        state;
    logic [IDX_W-1:0]              cur_idx;
    logic [HC_W-1:0]               hold_cnt;
    logic [IDX_W-1:0]              head;
    logic [DEPTH-1:0][IDX_W-1:0]   entries;
    logic [DEPTH-1:0]              valid;
    logic                          xfer;
    logic                          fifo_match;
    logic                          dup;
    logic                          push;
    logic                          pop;

    // Handshake: an index transfers on a rising edge where idx_valid and
    // idx_ready are both high; idx_ready depends on registered count only,
    // so a same-cycle pop never opens a full FIFO.
    assign idx_ready = fifo_count < CW'(DEPTH);
    assign xfer      = idx_valid && idx_ready;

    always_comb begin
        fifo_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i] == idx_in) begin
                fifo_match = 1'b1;
            end
        end
    end

    assign dup  = xfer && (fifo_match || (state == ACK && idx_in == cur_idx));
    assign push = xfer && !dup;
    assign pop  = (state == IDLE) && (fifo_count != '0);

    idx_fifo #(
        .DEPTH (DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .din     (idx_in),
        .dout    (head),
        .count   (fifo_count),
        .entries (entries),
        .valid   (valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ack_out   <= '0;
            ack_valid <= 1'b0;
            done      <= 1'b0;
            done_idx  <= '0;
            cur_idx   <= '0;
            hold_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        ack_out   <= onehot(head);
                        ack_valid <= 1'b1;
                        cur_idx   <= head;
                        hold_cnt  <= '0;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (hold_cnt < HOLD_LIM) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                    // Withdrawal only counts once the minimum hold has elapsed.
                    if ((hold_cnt + HC_W'(1) >= HOLD_LIM) && src_clr[cur_idx]) begin
                        ack_out   <= '0;
                        ack_valid <= 1'b0;
                        done      <= 1'b1;
                        done_idx  <= cur_idx;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dup_drop <= 1'b0;
        end else begin
            dup_drop <= dup;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_prio_ack_decoder.sv
// Cycle-by-cycle comparison of prio_ack_decoder against a queue-based
// behavioural model, with directed scenarios followed by random traffic.
module tb_prio_ack_decoder;
    import prio_pkg::*;

    localparam int DEPTH    = 4;
    localparam int HOLD_MIN = 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IDX_W-1:0] idx_in = '0;
    logic             idx_valid = 1'b0;
    logic             idx_ready;
    logic [N-1:0]     src_clr = '0;
    logic [N-1:0]     ack_out;
    logic             ack_valid;
    logic             done;
    logic [IDX_W-1:0] done_idx;
    logic             dup_drop;
    logic [CW-1:0]    fifo_count;
    state_t           fsm_state;

    prio_ack_decoder #(
        .DEPTH    (DEPTH),
        .HOLD_MIN (HOLD_MIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .idx_in     (idx_in),
        .idx_valid  (idx_valid),
        .idx_ready  (idx_ready),
        .src_clr    (src_clr),
        .ack_out    (ack_out),
        .ack_valid  (ack_valid),
        .done       (done),
        .done_idx   (done_idx),
        .dup_drop   (dup_drop),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending indices, the index being acknowledged,
    // how many cycles its ack has been visible, and a one-cycle gap flag.
    logic [IDX_W-1:0] exp_q[$];
    bit               m_busy;
    bit               m_gap;
    int               m_cur;
    int               m_held;
    logic [N-1:0]     m_ack;
    bit               m_done;
    int               m_done_idx;
    bit               m_dup;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [IDX_W-1:0] i,
                              input logic [N-1:0] clr, input bit r);
        bit hit;
        bit xfer;
        bit is_dup;
        if (r) begin
            exp_q.delete();
            m_busy = 0; m_gap = 0; m_cur = 0; m_held = 0;
            m_ack = '0; m_done = 0; m_done_idx = 0; m_dup = 0;
            return;
        end
        xfer = v && (exp_q.size() < DEPTH);
        hit = 0;
        foreach (exp_q[k]) if (exp_q[k] == i) hit = 1;
        if (m_busy && m_cur == int'(i)) hit = 1;
        is_dup = xfer && hit;
        m_dup  = is_dup;
        m_done = 0;
        if (m_gap) begin
            m_gap = 0;
        end else if (m_busy) begin
            if (m_held >= HOLD_MIN && clr[m_cur]) begin
                m_busy = 0; m_gap = 1; m_done = 1; m_done_idx = m_cur; m_ack = '0;
            end else begin
                m_held++;
            end
        end else if (exp_q.size() > 0) begin
            m_cur  = int'(exp_q.pop_front());
            m_busy = 1;
            m_held = 1;
            m_ack  = N'(1) << m_cur;
        end
        if (xfer && !is_dup) exp_q.push_back(i);
    endtask

    // Driver: apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step(input bit v, input logic [IDX_W-1:0] i,
                        input logic [N-1:0] clr, input bit r);
        rst = r; idx_valid = v; idx_in = i; src_clr = clr;
        model_edge(v, i, clr, r);
        @(posedge clk);
        #1;
        check("ack_out",    32'(ack_out),    32'(m_ack));
        check("ack_valid",  32'(ack_valid),  32'(m_ack != '0));
        check("done",       32'(done),       32'(m_done));
        check("dup_drop",   32'(dup_drop),   32'(m_dup));
        check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check("idx_ready",  32'(idx_ready),  32'(exp_q.size() < DEPTH));
        if (m_done || r) check("done_idx", 32'(done_idx), 32'(m_done_idx));
    endtask

    task automatic idle(input int n, input logic [N-1:0] clr);
        for (int k = 0; k < n; k++) step(1'b0, '0, clr, 1'b0);
    endtask

    function automatic logic [N-1:0] cur_clr();
        return m_busy ? (N'(1) << m_cur) : '0;
    endfunction

    initial begin
        // Reset with a pending valid that must be ignored
        step(1'b1, 3'd6, '0, 1'b1);
        step(1'b1, 3'd6, '0, 1'b1);

        // Single index with source already withdrawn
        step(1'b1, 3'd5, 8'h20, 1'b0);
        idle(6, 8'h20);

        // Fill the FIFO behind an active ack, stall, then drain in order
        step(1'b1, 3'd3, '0, 1'b0);
        step(1'b1, 3'd1, '0, 1'b0);
        step(1'b1, 3'd7, '0, 1'b0);
        step(1'b1, 3'd0, '0, 1'b0);
        step(1'b1, 3'd6, '0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 3'd2, '0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, 3'd2, cur_clr(), 1'b0);
        idle(6, 8'hff);

        // Duplicates against the active ack and a queued entry
        step(1'b1, 3'd4, '0, 1'b0);
        idle(2, '0);
        step(1'b1, 3'd2, '0, 1'b0);
        step(1'b1, 3'd4, '0, 1'b0);
        step(1'b1, 3'd2, '0, 1'b0);
        idle(3, '0);
        idle(20, 8'hff);

        // Foreign src_clr bit is ignored
        step(1'b1, 3'd6, '0, 1'b0);
        idle(2, '0);
        idle(4, 8'h01);
        idle(4, 8'h40);

        // Reset in the middle of an acknowledge with entries pending
        step(1'b1, 3'd3, '0, 1'b0);
        step(1'b1, 3'd5, '0, 1'b0);
        step(1'b1, 3'd7, '0, 1'b0);
        idle(2, '0);
        step(1'b0, '0, '0, 1'b1);
        step(1'b1, 3'd1, '0, 1'b0);
        idle(4, 8'h02);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            logic [N-1:0] clr;
            case ($urandom_range(0, 3))
                0:       clr = N'($urandom);
                1:       clr = cur_clr();
                default: clr = '0;
            endcase
            step($urandom_range(0, 1) == 1, IDX_W'($urandom_range(0, N - 1)), clr,
                 $urandom_range(0, 299) == 0);
        end
        idle(30, 8'hff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
